// File: rtl/subleq_mem_responder_pkg.sv
// Shared definitions for the SUBLEQ memory responder: FSM state encodings
// and the default memory-mapped I/O port addresses.
package subleq_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        READ_WAIT  = 2'd1,
        READ_VALID = 2'd2,
        WRITE_ACK  = 2'd3
    } state_t;

    localparam logic [15:0] DEFAULT_IO_OUT_ADDR = 16'hFFFE;
    localparam logic [15:0] DEFAULT_IO_IN_ADDR  = 16'hFFFF;

    localparam int COUNT_WIDTH = 4;

endpackage

// File: rtl/subleq_mem_responder_sram.sv
// Single-port RAM: synchronous write, combinational read. Contents are
// deliberately not reset so that data survives a processor reset.
module sram_sp #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  CLOCK,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Commit the write word on the rising edge when enabled.
    always_ff @(posedge CLOCK) begin
        if (write_enable) begin
            mem[addr] <= write_data;
        end
    end

    assign read_data = mem[addr];

endmodule

// File: rtl/subleq_mem_responder.sv
// Memory responder for a SUBLEQ processor: RAM plus one output port register
// and one input port, with a configurable read latency and an edge-triggered
// write handshake that is acknowledged by a one-cycle echo of the write data.
import subleq_mem_responder_pkg::*;

module subleq_mem_responder #(
    parameter int                             DATA_ADDR_WIDTH = 16,
    parameter int                             MEM_DEPTH       = 256,
    parameter int                             READ_LATENCY    = 2,
    parameter logic [DATA_ADDR_WIDTH-1:0]     IO_OUT_ADDR     = DATA_ADDR_WIDTH'(DEFAULT_IO_OUT_ADDR),
    parameter logic [DATA_ADDR_WIDTH-1:0]     IO_IN_ADDR      = DATA_ADDR_WIDTH'(DEFAULT_IO_IN_ADDR)
) (
    input  logic                       CLOCK,
    input  logic                       RESET_bar,
    input  logic [DATA_ADDR_WIDTH-1:0] ADDR_IN,
    input  logic [DATA_ADDR_WIDTH-1:0] DATA_IN,
    input  logic                       WRITE_VALID,
    output logic [DATA_ADDR_WIDTH-1:0] DATA_OUT,
    output logic                       DATA_OUT_VALID,
    input  logic [DATA_ADDR_WIDTH-1:0] IO_IN,
    output logic [DATA_ADDR_WIDTH-1:0] IO_OUT,
    output logic                       IO_OUT_STROBE
);

    localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // The counter is loaded with latency-1 so that the read completes
    // exactly READ_LATENCY edges after the capturing edge.
    localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(READ_LATENCY - 1);

    state_t                     state;
    logic [DATA_ADDR_WIDTH-1:0] held_addr;
    logic [COUNT_WIDTH-1:0]     count;
    logic                       write_prev;

    logic                       write_req;
    logic                       write_take;
    logic                       write_in_ram;
    logic                       held_in_ram;
    logic                       addr_changed;
    logic [RAM_AW-1:0]          ram_addr;
    logic [DATA_ADDR_WIDTH-1:0] ram_rdata;
    logic [DATA_ADDR_WIDTH-1:0] read_value;

    assign write_req    = WRITE_VALID && !write_prev;
    assign write_take   = RESET_bar && write_req && (state != WRITE_ACK);
    assign write_in_ram = (ADDR_IN != IO_IN_ADDR) && (ADDR_IN != IO_OUT_ADDR)
                          && (32'(ADDR_IN) < 32'(MEM_DEPTH));
    assign held_in_ram  = 32'(held_addr) < 32'(MEM_DEPTH);
    assign addr_changed = ADDR_IN != held_addr;

    // The single RAM port follows the write address only on a write edge,
    // which is also the edge on which no read can complete.
    assign ram_addr = write_take ? ADDR_IN[RAM_AW-1:0] : held_addr[RAM_AW-1:0];

    sram_sp #(
        .DATA_WIDTH (DATA_ADDR_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .ADDR_WIDTH (RAM_AW)
    ) u_sram (
        .CLOCK        (CLOCK),
        .write_enable (write_take && write_in_ram),
        .addr         (ram_addr),
        .write_data   (DATA_IN),
        .read_data    (ram_rdata)
    );

    // Decode the held address into the value a completing read returns.
    always_comb begin
        read_value = '0;
        if (held_addr == IO_IN_ADDR) begin
            read_value = IO_IN;
        end else if (held_addr == IO_OUT_ADDR) begin
            read_value = IO_OUT;
        end else if (held_in_ram) begin
            read_value = ram_rdata;
        end
    end

    // Responder FSM: writes preempt reads, reads complete after the latency.
    always_ff @(posedge CLOCK) begin
        if (!RESET_bar) begin
            state          <= IDLE;
            DATA_OUT       <= '0;
            DATA_OUT_VALID <= 1'b0;
            IO_OUT         <= '0;
            IO_OUT_STROBE  <= 1'b0;
            held_addr      <= '0;
            count          <= '0;
            write_prev     <= 1'b0;
        end else begin
            write_prev    <= WRITE_VALID;
            IO_OUT_STROBE <= 1'b0;
            if (write_take) begin
                DATA_OUT       <= DATA_IN;
                DATA_OUT_VALID <= 1'b1;
                state          <= WRITE_ACK;
                if ((ADDR_IN != IO_IN_ADDR) && (ADDR_IN == IO_OUT_ADDR)) begin
                    IO_OUT        <= DATA_IN;
                    IO_OUT_STROBE <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE, WRITE_ACK: begin
                        held_addr      <= ADDR_IN;
                        count          <= COUNT_LOAD;
                        DATA_OUT_VALID <= 1'b0;
                        state          <= READ_WAIT;
                    end
                    READ_WAIT: begin
                        if (addr_changed) begin
                            held_addr <= ADDR_IN;
                            count     <= COUNT_LOAD;
                        end else if (count == '0) begin
                            DATA_OUT       <= read_value;
                            DATA_OUT_VALID <= 1'b1;
                            state          <= READ_VALID;
                        end else begin
                            count <= count - 1'b1;
                        end
                    end
                    READ_VALID: begin
                        if (addr_changed) begin
                            held_addr      <= ADDR_IN;
                            count          <= COUNT_LOAD;
                            DATA_OUT_VALID <= 1'b0;
                            state          <= READ_WAIT;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_subleq_mem_responder.sv
// Directed testbench for subleq_mem_responder with READ_LATENCY = 2.
module tb_subleq_mem_responder;

    logic        CLOCK;
    logic        RESET_bar;
    logic [15:0] ADDR_IN;
    logic [15:0] DATA_IN;
    logic        WRITE_VALID;
    logic [15:0] DATA_OUT;
    logic        DATA_OUT_VALID;
    logic [15:0] IO_IN;
    logic [15:0] IO_OUT;
    logic        IO_OUT_STROBE;

    int checks = 0;
    int passes = 0;

    subleq_mem_responder #(
        .DATA_ADDR_WIDTH (16),
        .MEM_DEPTH       (256),
        .READ_LATENCY    (2),
        .IO_OUT_ADDR     (16'hFFFE),
        .IO_IN_ADDR      (16'hFFFF)
    ) dut (
        .CLOCK          (CLOCK),
        .RESET_bar      (RESET_bar),
        .ADDR_IN        (ADDR_IN),
        .DATA_IN        (DATA_IN),
        .WRITE_VALID    (WRITE_VALID),
        .DATA_OUT       (DATA_OUT),
        .DATA_OUT_VALID (DATA_OUT_VALID),
        .IO_IN          (IO_IN),
        .IO_OUT         (IO_OUT),
        .IO_OUT_STROBE  (IO_OUT_STROBE)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_write(input logic [15:0] addr, input logic [15:0] data);
        ADDR_IN = addr; DATA_IN = data; WRITE_VALID = 1'b1;
        tick();
        WRITE_VALID = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        RESET_bar = 1'b0; WRITE_VALID = 1'b0; ADDR_IN = '0; DATA_IN = '0; IO_IN = '0;
        tick(); tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", DATA_OUT_VALID); else passes++;
        checks++; if (DATA_OUT !== 16'h0000) $display("[TB] FAIL reset_data: got %h expected 0000", DATA_OUT); else passes++;
        checks++; if (IO_OUT !== 16'h0000) $display("[TB] FAIL reset_io_out: got %h expected 0000", IO_OUT); else passes++;
        checks++; if (IO_OUT_STROBE !== 1'b0) $display("[TB] FAIL reset_strobe: got %b expected 0", IO_OUT_STROBE); else passes++;
        RESET_bar = 1'b1;
    endtask

    task automatic test_read_latency();
        do_write(16'h0010, 16'hA5A5);
        RESET_bar = 1'b0; ADDR_IN = 16'h0010;
        tick();
        RESET_bar = 1'b1;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL lat_edge0_valid: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL lat_edge1_valid: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1) $display("[TB] FAIL lat_edge2_valid: got %b expected 1", DATA_OUT_VALID); else passes++;
        checks++; if (DATA_OUT !== 16'hA5A5) $display("[TB] FAIL lat_edge2_data: got %h expected a5a5", DATA_OUT); else passes++;
        tick(); tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'hA5A5)
            $display("[TB] FAIL lat_hold: got valid=%b data=%h expected valid=1 data=a5a5", DATA_OUT_VALID, DATA_OUT); else passes++;
    endtask

    task automatic test_write_read();
        ADDR_IN = 16'h0020; DATA_IN = 16'hBEEF; WRITE_VALID = 1'b1;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'hBEEF)
            $display("[TB] FAIL wr_ack: got valid=%b data=%h expected valid=1 data=beef", DATA_OUT_VALID, DATA_OUT); else passes++;
        checks++; if (IO_OUT_STROBE !== 1'b0) $display("[TB] FAIL wr_ram_strobe: got %b expected 0", IO_OUT_STROBE); else passes++;
        WRITE_VALID = 1'b0; DATA_IN = 16'h0000;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL wr_ack_one_cycle: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL raw_wait: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'hBEEF)
            $display("[TB] FAIL raw_data: got valid=%b data=%h expected valid=1 data=beef", DATA_OUT_VALID, DATA_OUT); else passes++;
    endtask

    task automatic test_io();
        int strobes;
        ADDR_IN = 16'hFFFE; DATA_IN = 16'h1234; WRITE_VALID = 1'b1;
        tick();
        checks++; if (IO_OUT !== 16'h1234 || IO_OUT_STROBE !== 1'b1)
            $display("[TB] FAIL io_out_write: got io_out=%h strobe=%b expected io_out=1234 strobe=1", IO_OUT, IO_OUT_STROBE); else passes++;
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h1234)
            $display("[TB] FAIL io_out_ack: got valid=%b data=%h expected valid=1 data=1234", DATA_OUT_VALID, DATA_OUT); else passes++;
        WRITE_VALID = 1'b0;
        strobes = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (IO_OUT_STROBE === 1'b1) strobes++;
        end
        tick();
        if (IO_OUT_STROBE === 1'b1) strobes++;
        checks++; if (strobes != 0) $display("[TB] FAIL io_strobe_single: got %0d extra pulses expected 0", strobes); else passes++;
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h1234)
            $display("[TB] FAIL io_out_readback: got valid=%b data=%h expected valid=1 data=1234", DATA_OUT_VALID, DATA_OUT); else passes++;
        IO_IN = 16'h00AA; ADDR_IN = 16'hFFFF;
        tick(); tick(); tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h00AA)
            $display("[TB] FAIL io_in_read: got valid=%b data=%h expected valid=1 data=00aa", DATA_OUT_VALID, DATA_OUT); else passes++;
        checks++; if (IO_OUT !== 16'h1234) $display("[TB] FAIL io_out_kept: got %h expected 1234", IO_OUT); else passes++;
    endtask

    task automatic test_addr_change();
        do_write(16'h0001, 16'h1111);
        do_write(16'h0002, 16'h2222);
        ADDR_IN = 16'h0005;
        tick(); tick(); tick(); tick();
        ADDR_IN = 16'h0001;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL chg_capture_valid: got %b expected 0", DATA_OUT_VALID); else passes++;
        ADDR_IN = 16'h0002;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL chg_recapture_valid: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL chg_no_old_valid: got %b data=%h expected 0", DATA_OUT_VALID, DATA_OUT); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h2222)
            $display("[TB] FAIL chg_new_data: got valid=%b data=%h expected valid=1 data=2222", DATA_OUT_VALID, DATA_OUT); else passes++;
    endtask

    task automatic test_back_to_back();
        ADDR_IN = 16'h0030; DATA_IN = 16'h7777; WRITE_VALID = 1'b1;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h7777)
            $display("[TB] FAIL hold_ack: got valid=%b data=%h expected valid=1 data=7777", DATA_OUT_VALID, DATA_OUT); else passes++;
        DATA_IN = 16'h8888;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL hold_no_second_ack: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick(); tick(); tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h7777)
            $display("[TB] FAIL hold_single_write: got valid=%b data=%h expected valid=1 data=7777", DATA_OUT_VALID, DATA_OUT); else passes++;
        WRITE_VALID = 1'b0;
        tick();
        ADDR_IN = 16'h0300; DATA_IN = 16'hDEAD; WRITE_VALID = 1'b1;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'hDEAD)
            $display("[TB] FAIL oob_ack: got valid=%b data=%h expected valid=1 data=dead", DATA_OUT_VALID, DATA_OUT); else passes++;
        WRITE_VALID = 1'b0;
        tick(); tick(); tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'h0000)
            $display("[TB] FAIL oob_read_zero: got valid=%b data=%h expected valid=1 data=0000", DATA_OUT_VALID, DATA_OUT); else passes++;
    endtask

    task automatic test_reset_mid_read();
        ADDR_IN = 16'h0040;
        tick();
        RESET_bar = 1'b0;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b0 || DATA_OUT !== 16'h0000)
            $display("[TB] FAIL midrst_data: got valid=%b data=%h expected valid=0 data=0000", DATA_OUT_VALID, DATA_OUT); else passes++;
        checks++; if (IO_OUT !== 16'h0000 || IO_OUT_STROBE !== 1'b0)
            $display("[TB] FAIL midrst_io: got io_out=%h strobe=%b expected io_out=0000 strobe=0", IO_OUT, IO_OUT_STROBE); else passes++;
        RESET_bar = 1'b1; ADDR_IN = 16'h0020;
        tick(); tick();
        checks++; if (DATA_OUT_VALID !== 1'b0) $display("[TB] FAIL midrst_wait: got %b expected 0", DATA_OUT_VALID); else passes++;
        tick();
        checks++; if (DATA_OUT_VALID !== 1'b1 || DATA_OUT !== 16'hBEEF)
            $display("[TB] FAIL midrst_retained: got valid=%b data=%h expected valid=1 data=beef", DATA_OUT_VALID, DATA_OUT); else passes++;
    endtask

    initial begin
        RESET_bar = 1'b0; WRITE_VALID = 1'b0; ADDR_IN = '0; DATA_IN = '0; IO_IN = '0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_io();
        test_addr_change();
        test_back_to_back();
        test_reset_mid_read();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/subleq_mem_responder.md
SUBLEQ_MEM_RESPONDER -- requirements
Module: subleq_mem_responder

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- DATA_ADDR_WIDTH, 16, data and address width.
- MEM_DEPTH, 256, number of RAM words.
- READ_LATENCY, 2, cycles from address capture to valid read data; legal range 1-15.
- IO_OUT_ADDR, 16'hFFFE, address of the output port register.
- IO_IN_ADDR, 16'hFFFF, address of the input port.
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- CLOCK, in, 1, single clock; all logic updates on the rising edge.
- RESET_bar, in, 1, reset; synchronous and active-low.
- ADDR_IN, in, DATA_ADDR_WIDTH, address from the processor's ADDR_OUT.
- DATA_IN, in, DATA_ADDR_WIDTH, write data from the processor's DATA_OUT.
- WRITE_VALID, in, 1, driven by the processor's DATA_OUT_VALID; a write request.
- DATA_OUT, out, DATA_ADDR_WIDTH, read data or write echo, to the processor's DATA_IN.
- DATA_OUT_VALID, out, 1, to the processor's DATA_IN_VALID; always driven, never high-Z.
- IO_IN, in, DATA_ADDR_WIDTH, external input port.
- IO_OUT, out, DATA_ADDR_WIDTH, external output port register.
- IO_OUT_STROBE, out, 1, one-cycle pulse on each IO_OUT update.

Function
REQ-003 The FSM states SHALL be IDLE, READ_WAIT, READ_VALID and WRITE_ACK.
REQ-004 A write request SHALL be a rising edge of WRITE_VALID (sampled 0 then 1); holding WRITE_VALID high SHALL NOT cause a repeated write.
REQ-005 A write request in any state except WRITE_ACK SHALL take priority over reads:
- commit DATA_IN to ADDR_IN;
- enter WRITE_ACK;
- abort any pending read.
REQ-006 WRITE_ACK SHALL last exactly one cycle with DATA_OUT_VALID=1 and DATA_OUT equal to the written data, then go to READ_WAIT capturing the current ADDR_IN.
REQ-007 IDLE SHALL unconditionally capture ADDR_IN into the held address, load the latency counter and enter READ_WAIT.
REQ-008 In READ_WAIT or READ_VALID, an ADDR_IN differing from the held address SHALL recapture it, reload the counter, deassert DATA_OUT_VALID and enter or restart READ_WAIT.
REQ-009 Read timing: for an address captured at edge N with a stable address and no write, DATA_OUT SHALL be loaded and DATA_OUT_VALID SHALL rise at edge N+READ_LATENCY, entering READ_VALID.
REQ-010 READ_VALID SHALL hold DATA_OUT and DATA_OUT_VALID=1 until an address change or a write request.
REQ-011 Address decode, checked in this order:
- IO_IN_ADDR: reads return IO_IN sampled at the completing edge; writes are ignored but acknowledged.
- IO_OUT_ADDR: reads return IO_OUT; writes load IO_OUT and pulse IO_OUT_STROBE for exactly one cycle.
- ADDR_IN < MEM_DEPTH: RAM access.
- Otherwise: reads return 0; writes are dropped but acknowledged.
REQ-012 Read-after-write to the same address SHALL return the newly written value.
REQ-013 A write request arriving during WRITE_ACK SHALL be taken only if WRITE_VALID shows a fresh rising edge afterwards.

Reset
REQ-014 While RESET_bar=0 at an edge, the block SHALL set:
- state to IDLE;
- DATA_OUT=0, DATA_OUT_VALID=0;
- IO_OUT=0, IO_OUT_STROBE=0;
- held address=0, counter=0;
- WRITE_VALID edge-detect register=0.
REQ-015 RAM contents SHALL NOT be cleared by reset.
REQ-016 Reset mid-read or mid-write SHALL abandon the operation; a write already committed at an earlier edge SHALL persist.

Structure
REQ-017 The shared package/include SHALL hold the FSM state encodings and the default IO_OUT_ADDR and IO_IN_ADDR values.
REQ-018 The RAM array SHALL be a separate sub-module, sram_sp: single-port, synchronous write, combinational read.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Reset, then ADDR_IN=0x0010 stable -> DATA_OUT_VALID=0 until 2 edges after capture, then DATA_OUT=RAM[0x10] with VALID=1.
- WRITE_VALID pulse with ADDR_IN=0x0020 and DATA_IN=0xBEEF -> one-cycle VALID with DATA_OUT=0xBEEF; the following read of 0x0020 returns 0xBEEF.
- Write 0x1234 to 0xFFFE -> IO_OUT=0x1234 with one IO_OUT_STROBE pulse; IO_IN=0x00AA with read of 0xFFFF -> DATA_OUT=0x00AA.
- ADDR_IN changes 0x0001->0x0002 one cycle after capture -> no VALID for 0x0001; VALID for 0x0002 two edges after the change.
- WRITE_VALID held high 5 cycles -> exactly one write and one acknowledge; write to 0x0300 (beyond MEM_DEPTH) is acknowledged and a later read returns 0.
- RESET_bar low mid-READ_WAIT -> outputs return to 0, then normal operation resumes; earlier RAM writes are retained.
